mod_mul_serial: RTL
===================

// Module: mod_mul_serial
// PURPOSE
//  Bit-serial modular multiplier: product = (a * b) mod P over the secp256k1 field.
//  MSB-first interleaved double-and-add; every step is two modular additions of the add/sub stage type.
//  Sits directly upstream of point-add/double datapath, feeding mod add/sub operands.
//  Start/done handshake; one b-bit per clock.
// PARAMETERS
//  P  256'hFFFF...FFFEFFFFFC2F  field prime (secp256k1); P < 2^256, P odd
//  W  256                       operand width; counter width = $clog2(W)
// PORTS
//  clk      in   1    single clock, all flops rising edge
//  reset    in   1    asynchronous, active-high; clears all state
//  start    in   1    request; sampled only in IDLE
//  a        in   W    multiplicand, caller guarantees a < P; latched on accepted start
//  b        in   W    multiplier, caller guarantees b < P; latched on accepted start
//  busy     out  1    high in RUN
//  done     out  1    one-cycle pulse, product valid
//  product  out  W    (a*b) mod P; held from done until next accepted start
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, product=0, acc=0, ctr=W-1, a_r=b_r=0.
//  States: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: start=1 -> latch a_r=a, b_r=b, acc=0, ctr=W-1, go RUN. start=0 -> stay.
//  RUN, per cycle:
//   - d = 2*acc mod P: 257-bit t=acc+acc; if t>=P then t-P else t.
//   - if b_r[ctr]: acc <= (d + a_r) mod P, same rule (257-bit sum, subtract P when >=P); else acc <= d.
//   - ctr==0 -> go DONE; else ctr <= ctr-1.
//  DONE: product <= acc, done=1 for exactly this cycle, go IDLE.
//  Latency: start accepted in cycle 0 -> RUN cycles 1..W -> done high in cycle W+1 (257).
//  Throughput: next start accepted in the cycle after done (earliest cycle W+2).
//  Invariant: acc < P after every RUN cycle; all intermediates 257 bits, no truncation before compare.
//  start while busy or in DONE: ignored, no queuing; a,b changes during RUN ignored.
//  product unchanged during RUN; updates only on DONE edge.
//  reset mid-RUN: immediate return to IDLE, product=0, no done pulse.
//  a=0 or b=0: full latency, product=0.
//  Operands >= P: result undefined; not checked.
// CONFIGURATION
//  MODMUL_EARLY_EXIT_EN defined:
//   - on accepted start ctr = index of most significant 1 of b (leading-zero skip);
//   - b==0: IDLE -> DONE directly, product=0, done in cycle 1;
//   - latency = msb_index(b)+2 cycles (b=1 -> done in cycle 1+1=2... RUN 1 cycle, done cycle 2).
//  MODMUL_EARLY_EXIT_EN undefined: fixed W+1 latency for all operands (constant-time; default).
//  Result value identical in both builds.
// TESTING
//  1. a=2, b=3, start 1 cycle -> busy cycles 1..256, done cycle 257, product=6.
//  2. a=P-1, b=P-1 -> product=1; a=P-1, b=2 -> product=P-2 (wrap on reduction).
//  3. a=0x1234, b=0 -> product=0; fixed build done cycle 257; EARLY_EXIT build done cycle 1.
//  4. start pulsed again at cycle 100 with different a,b -> ignored; product=original result at 257.
//  5. reset asserted cycle 50 of RUN -> busy=0, done=0, product=0 same cycle; new start then gives correct result.
//  6. 1000 random a,b < P vs. reference model (a*b)%P, back-to-back starts at cycle after done; EARLY_EXIT latency=msb(b)+2.

Source files
------------

// File: rtl/mod_mul_serial.sv
// Bit-serial MSB-first modular multiplier, product = (a * b) mod P, one multiplier bit per clock.
// Define MODMUL_EARLY_EXIT_EN to skip leading zeros of b; the default build is constant-time (W+1 cycles).
module mod_mul_serial #(
    parameter int           W = 256,
    parameter logic [W-1:0] P = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] product
);

    localparam int           cw      = $clog2(W);
    localparam logic [cw-1:0] ctr_max = cw'(W - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_next;
    logic [W-1:0]  acc, a_r, b_r;
    logic [cw-1:0] ctr, ctr_init;
    logic [W-1:0]  dbl, acc_step;

    // Both inputs are below P, so the W+1-bit sum needs at most one subtraction.
    function automatic logic [W-1:0] add_mod(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] t;
        t = {1'b0, x} + {1'b0, y};
        if (t >= {1'b0, P})
            t = t - {1'b0, P};
        return t[W-1:0];
    endfunction

`ifdef MODMUL_EARLY_EXIT_EN
    function automatic logic [cw-1:0] msb_index(input logic [W-1:0] v);
        logic [cw-1:0] idx;
        idx = '0;
        for (int i = 0; i < W; i++)
            if (v[i])
                idx = i[cw-1:0];
        return idx;
    endfunction

    assign ctr_init = msb_index(b);
`else
    assign ctr_init = ctr_max;
`endif

    always_comb begin
        dbl      = add_mod(acc, acc);
        acc_step = b_r[ctr] ? add_mod(dbl, a_r) : dbl;
    end

    // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it holding a value (which would infer a latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef MODMUL_EARLY_EXIT_EN
                    state_next = (b == '0) ? DONE : RUN;
`else
                    state_next = RUN;
`endif
                end
            end
            RUN:     if (ctr == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            acc     <= '0;
            ctr     <= ctr_max;
            a_r     <= '0;
            b_r     <= '0;
            product <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r <= a;
                        b_r <= b;
                        acc <= '0;
                        ctr <= ctr_init;
`ifdef MODMUL_EARLY_EXIT_EN
                        if (b == '0)
                            product <= '0;
`endif
                    end
                end
                RUN: begin
                    acc <= acc_step;
                    // Product is loaded on the edge into DONE so it is already valid while done is high.
                    if (ctr == '0)
                        product <= acc_step;
                    else
                        ctr <= ctr - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
